// File: rtl/counter_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_mon_pkg : shared types and helpers for counter monitoring     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package counter_mon_pkg;

   typedef enum logic [1:0] {INIT, TRACK, STALLED, ERROR} trk_state_t;

   typedef enum logic [1:0] {INC, HOLD, JUMP} step_t;

   localparam int c_delta_w = 64;

   // Callers truncate the result to their own width to get the modular step.
   function automatic logic [c_delta_w-1:0] step_delta(input logic [c_delta_w-1:0] cur,
                                                       input logic [c_delta_w-1:0] prv);
      return cur - prv;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_stall_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_stall_timer : saturating run counter of unchanged samples     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module counter_stall_timer #(
   parameter int STALL_LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic restart,
   output logic expired
);

   localparam int                c_cnt_w = $clog2(STALL_LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STALL_LIMIT);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run <= '0;
      end else if (restart) begin
         r_run <= '0;
      end else if (hold && (r_run != c_limit)) begin
         r_run <= r_run + c_one;
      end
   end

   // Looks ahead so the owner can change state on the sample that completes the run.
   assign expired = (r_run == c_limit) || (hold && (r_run == (c_limit - c_one)));

endmodule
`default_nettype wire

// File: rtl/counter_wrap_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_wrap_tracker : extends a wrapping counter and flags anomalies |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module counter_wrap_tracker
   import counter_mon_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EXT_WIDTH   = 8,
   parameter int STALL_LIMIT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           count_in,
   input  logic                       clear,
   output logic [EXT_WIDTH+WIDTH-1:0] full_count,
   output logic [EXT_WIDTH-1:0]       wrap_cnt,
   output logic                       wrap_pulse,
   output logic                       wrap_ovf,
   output logic                       stall,
   output logic                       err_jump,
   output logic [1:0]                 state
);

   localparam logic [WIDTH-1:0]     c_cnt_max  = '1;
   localparam logic [EXT_WIDTH-1:0] c_wrap_max = '1;

   trk_state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0]     r_prev, w_prev_nxt;
   logic [EXT_WIDTH-1:0] r_wrap_cnt, w_wrap_cnt_nxt;
   logic                 r_wrap_pulse, w_wrap_pulse_nxt;
   logic                 r_wrap_ovf, w_wrap_ovf_nxt;
   logic                 r_stall, w_stall_nxt;
   logic                 r_err_jump, w_err_jump_nxt;

   logic [WIDTH-1:0]     w_delta;
   step_t                w_step;
   logic                 w_active;
   logic                 w_hold;
   logic                 w_restart;
   logic                 w_expired;

   assign w_delta  = WIDTH'(step_delta(c_delta_w'(count_in), c_delta_w'(r_prev)));
   assign w_step   = (w_delta == WIDTH'(1)) ? INC : ((w_delta == '0) ? HOLD : JUMP);
   assign w_active = (r_state == TRACK) || (r_state == STALLED);

   // Kept outside the FSM process so the timer's look-ahead does not form a loop.
   assign w_hold    = !clear && w_active && (w_step == HOLD);
   assign w_restart = clear || (r_state == INIT) || (w_active && (w_step == INC));

   counter_stall_timer #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_timer (
      .clk     (clk),
      .rst     (rst),
      .hold    (w_hold),
      .restart (w_restart),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= INIT;
         r_prev       <= '0;
         r_wrap_cnt   <= '0;
         r_wrap_pulse <= 1'b0;
         r_wrap_ovf   <= 1'b0;
         r_stall      <= 1'b0;
         r_err_jump   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev       <= w_prev_nxt;
         r_wrap_cnt   <= w_wrap_cnt_nxt;
         r_wrap_pulse <= w_wrap_pulse_nxt;
         r_wrap_ovf   <= w_wrap_ovf_nxt;
         r_stall      <= w_stall_nxt;
         r_err_jump   <= w_err_jump_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_prev_nxt       = r_prev;
      w_wrap_cnt_nxt   = r_wrap_cnt;
      w_wrap_pulse_nxt = 1'b0;
      w_wrap_ovf_nxt   = r_wrap_ovf;
      w_stall_nxt      = r_stall;
      w_err_jump_nxt   = r_err_jump;

      if (clear) begin
         w_state_nxt    = INIT;
         w_prev_nxt     = '0;
         w_wrap_cnt_nxt = '0;
         w_wrap_ovf_nxt = 1'b0;
         w_stall_nxt    = 1'b0;
         w_err_jump_nxt = 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               w_prev_nxt  = count_in;
               w_state_nxt = TRACK;
            end
            TRACK, STALLED: begin
               case (w_step)
                  INC: begin
                     w_prev_nxt  = count_in;
                     w_stall_nxt = 1'b0;
                     w_state_nxt = TRACK;
                     if (r_prev == c_cnt_max) begin
                        w_wrap_pulse_nxt = 1'b1;
                        if (r_wrap_cnt == c_wrap_max) begin
                           w_wrap_ovf_nxt = 1'b1;
                        end else begin
                           w_wrap_cnt_nxt = r_wrap_cnt + EXT_WIDTH'(1);
                        end
                     end
                  end
                  HOLD: begin
                     if (w_expired) begin
                        w_stall_nxt = 1'b1;
                        w_state_nxt = STALLED;
                     end
                  end
                  default: begin
                     w_err_jump_nxt = 1'b1;
                     w_state_nxt    = ERROR;
                  end
               endcase
            end
            default: begin
               w_wrap_pulse_nxt = r_wrap_pulse;
            end
         endcase
      end
   end

   assign full_count = {r_wrap_cnt, r_prev};
   assign wrap_cnt   = r_wrap_cnt;
   assign wrap_pulse = r_wrap_pulse;
   assign wrap_ovf   = r_wrap_ovf;
   assign stall      = r_stall;
   assign err_jump   = r_err_jump;
   assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_wrap_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_wrap_tracker : directed + random bench with a step model   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_counter_wrap_tracker;

   localparam int W   = 4;
   localparam int EW  = 8;
   localparam int LIM = 4;
   localparam int MOD = 2 ** W;

   logic            clk;
   logic            rst;
   logic [W-1:0]    count_in;
   logic            clear;
   logic [EW+W-1:0] full_count;
   logic [EW-1:0]   wrap_cnt;
   logic            wrap_pulse;
   logic            wrap_ovf;
   logic            stall;
   logic            err_jump;
   logic [1:0]      state;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: abstract tracker status, not a copy of the FSM.
   bit m_started, m_err, m_stalled, m_pulse, m_ovf;
   int m_run, m_prev, m_wraps;

   counter_wrap_tracker #(
      .WIDTH       (W),
      .EXT_WIDTH   (EW),
      .STALL_LIMIT (LIM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .clear      (clear),
      .full_count (full_count),
      .wrap_cnt   (wrap_cnt),
      .wrap_pulse (wrap_pulse),
      .wrap_ovf   (wrap_ovf),
      .stall      (stall),
      .err_jump   (err_jump),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_err = 0; m_stalled = 0; m_pulse = 0; m_ovf = 0;
      m_run = 0; m_prev = 0; m_wraps = 0;
   endtask

   task automatic model_step(input int x, input bit clr);
      int d;
      m_pulse = 0;
      if (clr) begin
         model_reset();
         return;
      end
      if (m_err) return;
      if (!m_started) begin
         m_started = 1;
         m_prev    = x;
         m_run     = 0;
         return;
      end
      d = (x - m_prev + MOD) % MOD;
      if (d == 1) begin
         if (m_prev == MOD - 1) begin
            m_pulse = 1;
            if (m_wraps == 2 ** EW - 1) m_ovf = 1;
            else m_wraps++;
         end
         m_prev    = x;
         m_run     = 0;
         m_stalled = 0;
      end else if (d == 0) begin
         if (m_run < LIM) m_run++;
         if (m_run >= LIM) m_stalled = 1;
      end else begin
         m_err = 1;
      end
   endtask

   function automatic int exp_state();
      if (!m_started) return 0;
      if (m_err) return 3;
      if (m_stalled) return 2;
      return 1;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".state"},      32'(state),      32'(exp_state()));
      chk({tag, ".full_count"}, 32'(full_count), 32'(m_wraps * MOD + m_prev));
      chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(m_wraps));
      chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_pulse));
      chk({tag, ".wrap_ovf"},   32'(wrap_ovf),   32'(m_ovf));
      chk({tag, ".stall"},      32'(stall),      32'(m_stalled));
      chk({tag, ".err_jump"},   32'(err_jump),   32'(m_err));
   endtask

   task automatic cycle(input int x, input bit clr, input string tag);
      count_in = W'(x);
      clear    = clr;
      @(posedge clk);
      model_step(x, clr);
      #1;
      check_all(tag);
   endtask

   int pulses;

   initial begin
      rst = 1'b0; clear = 1'b0; count_in = '0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // Free run: 0..15, 0..15, 0..3
      pulses = 0;
      for (int i = 0; i < 36; i++) begin
         cycle(i % MOD, 1'b0, "free");
         if (wrap_pulse) pulses++;
      end
      chk("free.pulses", 32'(pulses), 32'd2);
      chk("free.final",  32'(full_count), 32'h023);

      // Stall: count to 5, hold 5 five times, then 6
      cycle(0, 1'b1, "clr1");
      for (int i = 0; i <= 5; i++) cycle(i, 1'b0, "stall.up");
      for (int rep = 1; rep <= 5; rep++) begin
         cycle(5, 1'b0, "stall.hold");
         chk("stall.level", 32'(stall), 32'(rep >= LIM));
      end
      cycle(6, 1'b0, "stall.exit");
      chk("stall.fell", 32'(stall), 32'd0);

      // Jump: 3,4,9 then frozen, then clear
      cycle(0, 1'b1, "clr2");
      cycle(3, 1'b0, "jump.base");
      cycle(4, 1'b0, "jump.inc");
      cycle(9, 1'b0, "jump.bad");
      chk("jump.err",   32'(err_jump),   32'd1);
      chk("jump.state", 32'(state),      32'd3);
      chk("jump.full",  32'(full_count), 32'h004);
      cycle(5, 1'b0, "jump.frozen");
      cycle(10, 1'b0, "jump.frozen");
      cycle(10, 1'b1, "jump.clear");
      chk("jump.clr_state", 32'(state),    32'd0);
      chk("jump.clr_err",   32'(err_jump), 32'd0);

      // Simultaneous stall exit and wrap
      cycle(14, 1'b0, "sw.base");
      cycle(15, 1'b0, "sw.inc");
      for (int rep = 0; rep < LIM; rep++) cycle(15, 1'b0, "sw.hold");
      chk("sw.stalled", 32'(stall), 32'd1);
      cycle(0, 1'b0, "sw.exit");
      chk("sw.stall",  32'(stall),      32'd0);
      chk("sw.pulse",  32'(wrap_pulse), 32'd1);
      chk("sw.wraps",  32'(wrap_cnt),   32'd1);

      // Saturation: 256 wraps from a cleared tracker
      cycle(0, 1'b1, "clr3");
      cycle(0, 1'b0, "sat.base");
      for (int w = 0; w < 256; w++)
         for (int v = 1; v <= MOD; v++) cycle(v % MOD, 1'b0, "sat");
      chk("sat.wrap_cnt", 32'(wrap_cnt),   32'd255);
      chk("sat.ovf",      32'(wrap_ovf),   32'd1);
      chk("sat.pulse",    32'(wrap_pulse), 32'd1);

      // Reset mid-run at wrap_cnt=3
      cycle(0, 1'b1, "clr4");
      cycle(0, 1'b0, "rr.base");
      for (int i = 1; i <= 3 * MOD + 5; i++) cycle(i % MOD, 1'b0, "rr.run");
      chk("rr.pre", 32'(wrap_cnt), 32'd3);
      rst = 1'b0;
      model_reset();
      #1;
      check_all("rr.async");
      repeat (2) @(posedge clk);
      #1;
      check_all("rr.held");
      count_in = W'(11);
      rst = 1'b1;
      cycle(11, 1'b0, "rr.base2");
      cycle(12, 1'b0, "rr.inc");
      chk("rr.full", 32'(full_count), 32'h00C);
      chk("rr.err",  32'(err_jump),   32'd0);

      // Randomized steps against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         int x;
         bit c;
         r = int'($urandom_range(99));
         c = 1'b0;
         if (r < 70)      x = (m_prev + 1) % MOD;
         else if (r < 88) x = m_prev;
         else if (r < 95) x = int'($urandom_range(MOD - 1));
         else begin
            x = int'($urandom_range(MOD - 1));
            c = 1'b1;
         end
         cycle(x, c, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/counter_wrap_tracker.md
# counter_wrap_tracker

Downstream consumer of the customer counter's `out` bus. Samples the counter value every cycle, extends it with a wrap count into a wider monotonic count, and classifies each step as increment, wrap, stall or illegal jump. Provides a sticky error and a stall indication to the surrounding system; it is the RTL counterpart of the checks the counter's formal properties express.

## Interface
- `WIDTH`, 4: width of the sampled counter value; must match the counter.
- `EXT_WIDTH`, 8: width of the wrap count.
- `STALL_LIMIT`, 16: consecutive unchanged samples that declare a stall; must be ≥ 1.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `count_in`  in  WIDTH  counter value, connected to the counter's `out`.
- `clear`  in  1  synchronous restart to INIT; highest priority after reset.
- `full_count`  out  EXT_WIDTH+WIDTH  `{wrap_cnt, last accepted count_in}`.
- `wrap_cnt`  out  EXT_WIDTH  number of wraps observed.
- `wrap_pulse`  out  1  one-cycle pulse per wrap.
- `wrap_ovf`  out  1  sticky; `wrap_cnt` saturated.
- `stall`  out  1  level; counter held for ≥ STALL_LIMIT samples.
- `err_jump`  out  1  sticky; illegal step seen.
- `state`  out  2  current FSM state (debug).

## Operation
- `prev` holds the last accepted sample; step `delta = count_in - prev`, modulo 2^WIDTH.
- States: INIT, TRACK, STALLED, ERROR.
- INIT: load `prev <= count_in`, no classification, go to TRACK.
- TRACK:
  - `delta==1`: accept, clear the stall run.
  - `delta==1` with `prev==2^WIDTH-1`: this is a wrap. `wrap_cnt` increments and `wrap_pulse` goes high. At all-ones, `wrap_cnt` holds and `wrap_ovf` is set instead.
  - `delta==0`: increment the stall run. When it reaches STALL_LIMIT, go to STALLED and assert `stall`.
  - Any other delta: set `err_jump`, go to ERROR, do not update `prev`/`wrap_cnt`.
- STALLED:
  - `delta==0`: stay; the run counter saturates.
  - `delta==1`: accept the step (wrap rules apply), deassert `stall`, clear the run, go to TRACK.
  - Any other delta: set `err_jump`, go to ERROR.
- ERROR: all outputs frozen, `err_jump` held. Exit only via `clear` or `rst`.
- `clear`: go to INIT. Zero `wrap_cnt`, the run, all flags and `full_count`. It overrides any same-cycle event.
- Values on reset (also applied by `clear`):
  - `state`: INIT.
  - `prev`, `full_count`, `wrap_cnt`: 0.
  - `wrap_pulse`, `wrap_ovf`, `stall`, `err_jump`: 0.
- Reset mid-operation: immediate return to INIT values. The first sample after release is taken as the baseline, with no error.

## Timing
- All outputs are registered; latency is one cycle from the sampling edge.
- `wrap_pulse` is high for exactly the cycle after the edge that samples the wrapping value.
- `stall` rises on the edge that samples the STALL_LIMIT-th consecutive equal value, counted after a change or after INIT. It falls on the edge that accepts the next increment.
- `err_jump` rises on the edge that samples the illegal value.
- Wrap and stall exit in the same cycle: both effects apply, so `wrap_pulse=1` and `stall=0`.
- `wrap_cnt` and `full_count` update on the same edge as `wrap_pulse`.

## Structure
- Shared package `counter_mon_pkg`:
  - `typedef enum logic [1:0] {INIT, TRACK, STALLED, ERROR} trk_state_t`.
  - Step classification enum: INC, HOLD, JUMP.
  - Function `step_delta` (modular subtract).
- Sub-module `counter_stall_timer`: run counter of width `$clog2(STALL_LIMIT+1)`.
  - Ports: `clk`, `rst`, `hold`, `restart`, `expired`.
  - `expired` stays high while saturated.
- Top level: FSM, `prev`/`wrap_cnt` registers, output flops.

## Test plan
All cases use WIDTH=4, EXT_WIDTH=8, STALL_LIMIT=4.
- **Free run:** count 0..15,0..15,0..3 after reset.
  - Expect `wrap_pulse` twice, each one cycle after `count_in=0` is sampled.
  - End state: `wrap_cnt=2`, `full_count=0x023`, no flags.
- **Stall:** count to 5, hold 5 for 5 cycles, then 6.
  - `stall` rises the cycle after the 4th repeated 5 and falls the cycle after 6 is sampled.
  - `err_jump=0` throughout.
- **Jump:** sequence 3,4,9.
  - `err_jump=1` and `state=ERROR` one cycle after 9.
  - Outputs frozen at `full_count=0x004`.
  - `clear` for one cycle returns `state` to INIT and drops `err_jump`.
- **Saturation:** preload by running 255 wraps, then one more.
  - `wrap_cnt` holds 255 and `wrap_ovf=1`; `wrap_pulse` still fires.
- **Reset mid-run:** at `wrap_cnt=3`, assert `rst` low for 2 cycles; release with `count_in=11`.
  - All outputs read 0 immediately.
  - Then 12 accepted with no `err_jump`, `full_count=0x00C`.
- **Simultaneous stall exit and wrap:** hold 15 for 4 cycles, then 0.
  - `stall` falls, `wrap_pulse=1` and `wrap_cnt` increments, all in the same cycle.
